// File: rtl/data_cache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a
// word-serial refill engine on a request/acknowledge memory port.
module data_cache_wt #(
   parameter int unsigned LINES = 16,
   parameter int unsigned WORDS = 16
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [1:0]  i_size,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_done,
   output logic        o_err,
   input  logic        i_flush,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_ack,
   output logic [15:0] o_hit_count,
   output logic [15:0] o_miss_count
);
   localparam int unsigned IDX_W = $clog2(LINES);
   localparam int unsigned OFF_W = $clog2(WORDS);
   localparam int unsigned TAG_W = 32 - IDX_W - OFF_W - 2;

   typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_RESP} state_t;

   state_t             r_state;
   logic [LINES-1:0]   r_valid;
   logic [TAG_W-1:0]   r_tag  [LINES];
   logic [31:0]        r_data [LINES][WORDS];
   logic [31:2]        r_addr;
   logic [OFF_W-1:0]   r_beat;

   logic [TAG_W-1:0]   w_tag;
   logic [IDX_W-1:0]   w_idx, r_idx;
   logic [OFF_W-1:0]   w_word, r_word;
   logic               w_hit, w_misal, w_accept, w_store_upd, w_refill_wr, w_last;
   logic [3:0]         w_strb;
   logic [31:0]        w_wrep;

   assign w_tag  = i_addr[31 -: TAG_W];
   assign w_idx  = i_addr[OFF_W+2 +: IDX_W];
   assign w_word = i_addr[2 +: OFF_W];
   assign r_idx  = r_addr[OFF_W+2 +: IDX_W];
   assign r_word = r_addr[2 +: OFF_W];

   assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
   assign w_misal     = ((i_size == 2'b01) && i_addr[0]) || (i_size[1] && (i_addr[1:0] != 2'b00));
   assign w_accept    = (r_state == S_IDLE) && !i_flush && i_req;
   assign w_store_upd = w_accept && i_we && !w_misal && w_hit;
   assign w_refill_wr = (r_state == S_REFILL) && i_mem_ack;
   assign w_last      = (r_beat == OFF_W'(WORDS - 1));

   // Store lane enables and lane-replicated write data
   always_comb begin
      w_strb = 4'b1111;
      w_wrep = i_wdata;
      case (i_size)
         2'b00: begin
            w_strb = 4'b0001 << i_addr[1:0];
            w_wrep = {4{i_wdata[7:0]}};
         end
         2'b01: begin
            w_strb = i_addr[1] ? 4'b1100 : 4'b0011;
            w_wrep = {2{i_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // Data and tag arrays need no reset; validity lives in r_valid
   always_ff @(posedge i_clk) begin
      if (w_store_upd) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) r_data[w_idx][w_word][8*b +: 8] <= w_wrep[8*b +: 8];
         end
      end
      if (w_refill_wr) begin
         r_data[r_idx][r_beat] <= i_mem_rdata;
         if (w_last) r_tag[r_idx] <= r_addr[31 -: TAG_W];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_valid      <= '0;
         r_addr       <= '0;
         r_beat       <= '0;
         o_hit_count  <= '0;
         o_miss_count <= '0;
         o_done       <= 1'b0;
         o_err        <= 1'b0;
         o_rdata      <= '0;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_wdata  <= '0;
         o_mem_wstrb  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_flush) begin
                  r_valid <= '0;
               end else if (i_req) begin
                  r_addr <= i_addr[31:2];
                  o_err  <= 1'b0;
                  if (w_misal) begin
                     o_err   <= 1'b1;
                     o_done  <= 1'b1;
                     r_state <= S_RESP;
                  end else if (!i_we) begin
                     if (w_hit) begin
                        o_rdata     <= r_data[w_idx][w_word];
                        o_hit_count <= o_hit_count + 16'd1;
                        o_done      <= 1'b1;
                        r_state     <= S_RESP;
                     end else begin
                        o_miss_count <= o_miss_count + 16'd1;
                        o_mem_req    <= 1'b1;
                        o_mem_we     <= 1'b0;
                        o_mem_wstrb  <= 4'b0000;
                        o_mem_addr   <= {i_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
                        r_beat       <= '0;
                        r_state      <= S_REFILL;
                     end
                  end else begin
                     if (w_hit) o_hit_count  <= o_hit_count + 16'd1;
                     else       o_miss_count <= o_miss_count + 16'd1;
                     o_mem_req   <= 1'b1;
                     o_mem_we    <= 1'b1;
                     o_mem_addr  <= {i_addr[31:2], 2'b00};
                     o_mem_wdata <= w_wrep;
                     o_mem_wstrb <= w_strb;
                     r_state     <= S_WRITE;
                  end
               end
            end
            S_REFILL: begin
               if (i_mem_ack) begin
                  if (w_last) begin
                     r_valid[r_idx] <= 1'b1;
                     // Requested word is either this beat or already in the array
                     o_rdata   <= (r_word == r_beat) ? i_mem_rdata : r_data[r_idx][r_word];
                     o_mem_req <= 1'b0;
                     r_beat    <= '0;
                     o_done    <= 1'b1;
                     r_state   <= S_RESP;
                  end else begin
                     r_beat     <= r_beat + OFF_W'(1);
                     o_mem_addr <= o_mem_addr + 32'd4;
                  end
               end
            end
            S_WRITE: begin
               if (i_mem_ack) begin
                  o_mem_req <= 1'b0;
                  o_mem_we  <= 1'b0;
                  o_done    <= 1'b1;
                  r_state   <= S_RESP;
               end
            end
            default: begin
               o_done  <= 1'b0;
               o_err   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_data_cache_wt.sv
// Directed testbench for data_cache_wt: memory returns its own word address.
module tb_data_cache_wt;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, we = 1'b0, flush = 1'b0;
   logic [1:0]  size = 2'b10;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        done, err, mem_req, mem_we, mem_ack;
   logic [3:0]  mem_wstrb;
   logic [15:0] hit_count, miss_count;

   int checks = 0, errors = 0;
   int ack_wait = 0, wcnt = 0;
   int rd_beats = 0, wr_beats = 0, stab_err = 0;
   logic [31:0] first_rd, last_rd, last_wa, last_wd;
   logic [3:0]  last_ws;
   logic        prev_pend = 1'b0;
   logic [31:0] prev_addr = '0;

   always #5 clk = ~clk;

   data_cache_wt dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_we(we), .i_size(size),
      .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_done(done), .o_err(err),
      .i_flush(flush), .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb), .i_mem_rdata(mem_rdata),
      .i_mem_ack(mem_ack), .o_hit_count(hit_count), .o_miss_count(miss_count)
   );

   assign mem_rdata = mem_addr;
   assign mem_ack   = mem_req && (wcnt >= ack_wait);

   always @(posedge clk) wcnt <= (mem_req && !mem_ack) ? wcnt + 1 : 0;

   // Beat monitor plus request stability check
   always @(negedge clk) begin
      if (prev_pend && (!mem_req || mem_addr !== prev_addr)) stab_err++;
      prev_pend = mem_req && !mem_ack;
      prev_addr = mem_addr;
      if (mem_req && mem_ack) begin
         if (mem_we) begin
            wr_beats++; last_wa = mem_addr; last_wd = mem_wdata; last_ws = mem_wstrb;
         end else begin
            if (dut.r_beat == '0) first_rd = mem_addr;
            last_rd = mem_addr; rd_beats++;
         end
      end
   end

   task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int cyc);
      logic got;
      got = 1'b0; rd = '0; er = 1'b0; cyc = 0;
      @(negedge clk); #1;
      req = 1'b1; we = w; size = sz; addr = a; wdata = wd;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk); #1; cyc++;
         if (done) begin rd = rdata; er = err; got = 1'b1; break; end
      end
      req = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL timeout addr=%h: no done within 200 cycles", a);
      end
   endtask

   task automatic test_reset;
      checks++; if (done !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL reset_ctl: done=%b mem_req=%b want 0 0", done, mem_req); end
      checks++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: %0d %0d want 0 0", hit_count, miss_count); end
      checks++; if (rdata !== 32'd0 || mem_addr !== 32'd0 || mem_wstrb !== 4'd0) begin errors++; $display("FAIL reset_data: rdata=%h addr=%h strb=%b want 0", rdata, mem_addr, mem_wstrb); end
   endtask

   task automatic test_cold_load;
      logic [31:0] rd; logic er; int cyc, rb;
      rb = rd_beats;
      access(1'b0, 2'b10, 32'h40, 32'h0, rd, er, cyc);
      checks++; if (rd_beats - rb !== 16 || first_rd !== 32'h40 || last_rd !== 32'h7C) begin errors++; $display("FAIL cold_beats: n=%0d first=%h last=%h want 16 40 7c", rd_beats - rb, first_rd, last_rd); end
      checks++; if (rd !== 32'h40 || cyc !== 17) begin errors++; $display("FAIL cold_rdata: rdata=%h cyc=%0d want 40 17", rd, cyc); end
      checks++; if (miss_count !== 16'd1) begin errors++; $display("FAIL cold_miss: %0d want 1", miss_count); end
      access(1'b0, 2'b10, 32'h44, 32'h0, rd, er, cyc);
      checks++; if (rd !== 32'h44 || cyc !== 1 || hit_count !== 16'd1) begin errors++; $display("FAIL hit_load: rdata=%h cyc=%0d hits=%0d want 44 1 1", rd, cyc, hit_count); end
   endtask

   task automatic test_sub_word_store;
      logic [31:0] rd; logic er; int cyc;
      access(1'b1, 2'b00, 32'h45, 32'h000000AB, rd, er, cyc);
      checks++; if (last_ws !== 4'b0010 || last_wd !== 32'hABABABAB || last_wa !== 32'h44) begin errors++; $display("FAIL byte_store: strb=%b data=%h addr=%h want 0010 abababab 44", last_ws, last_wd, last_wa); end
      checks++; if (cyc !== 2 || er !== 1'b0 || hit_count !== 16'd2) begin errors++; $display("FAIL byte_store_resp: cyc=%0d err=%b hits=%0d want 2 0 2", cyc, er, hit_count); end
      access(1'b0, 2'b10, 32'h44, 32'h0, rd, er, cyc);
      checks++; if (rd !== 32'h0000AB44) begin errors++; $display("FAIL byte_merge: rdata=%h want 0000ab44", rd); end
      access(1'b1, 2'b01, 32'h46, 32'h1234CDEF, rd, er, cyc);
      checks++; if (last_ws !== 4'b1100 || last_wd !== 32'hCDEFCDEF) begin errors++; $display("FAIL half_store: strb=%b data=%h want 1100 cdefcdef", last_ws, last_wd); end
      access(1'b0, 2'b10, 32'h44, 32'h0, rd, er, cyc);
      checks++; if (rd !== 32'hCDEFAB44 || hit_count !== 16'd5) begin errors++; $display("FAIL half_merge: rdata=%h hits=%0d want cdefab44 5", rd, hit_count); end
   endtask

   task automatic test_store_miss;
      logic [31:0] rd; logic er; int cyc, rb, wb;
      rb = rd_beats; wb = wr_beats;
      access(1'b1, 2'b10, 32'h1000, 32'hDEADBEEF, rd, er, cyc);
      checks++; if (wr_beats - wb !== 1 || rd_beats !== rb || last_ws !== 4'b1111 || last_wd !== 32'hDEADBEEF) begin errors++; $display("FAIL store_miss: wr=%0d rd=%0d strb=%b data=%h want 1 0 1111 deadbeef", wr_beats - wb, rd_beats - rb, last_ws, last_wd); end
      checks++; if (miss_count !== 16'd2) begin errors++; $display("FAIL store_miss_cnt: %0d want 2", miss_count); end
      access(1'b0, 2'b10, 32'h1000, 32'h0, rd, er, cyc);
      checks++; if (rd_beats - rb !== 16 || rd !== 32'h1000 || miss_count !== 16'd3) begin errors++; $display("FAIL no_allocate: beats=%0d rdata=%h miss=%0d want 16 1000 3", rd_beats - rb, rd, miss_count); end
   endtask

   task automatic test_conflict;
      logic [31:0] rd; logic er; int cyc, rb;
      ack_wait = 2; rb = rd_beats;
      access(1'b0, 2'b10, 32'h440, 32'h0, rd, er, cyc);
      checks++; if (rd_beats - rb !== 16 || rd !== 32'h440 || cyc !== 49) begin errors++; $display("FAIL conflict_fill: beats=%0d rdata=%h cyc=%0d want 16 440 49", rd_beats - rb, rd, cyc); end
      access(1'b0, 2'b10, 32'h40, 32'h0, rd, er, cyc);
      checks++; if (rd_beats - rb !== 32 || rd !== 32'h40 || miss_count !== 16'd5) begin errors++; $display("FAIL conflict_back: beats=%0d rdata=%h miss=%0d want 32 40 5", rd_beats - rb, rd, miss_count); end
      checks++; if (stab_err !== 0) begin errors++; $display("FAIL mem_stable: %0d changes before ack want 0", stab_err); end
      ack_wait = 0;
   endtask

   task automatic test_misaligned;
      logic [31:0] rd; logic er; int cyc, rb, wb;
      rb = rd_beats; wb = wr_beats;
      access(1'b0, 2'b10, 32'h42, 32'h0, rd, er, cyc);
      checks++; if (er !== 1'b1 || cyc !== 1) begin errors++; $display("FAIL mis_word: err=%b cyc=%0d want 1 1", er, cyc); end
      access(1'b1, 2'b01, 32'h43, 32'h5555, rd, er, cyc);
      checks++; if (er !== 1'b1) begin errors++; $display("FAIL mis_half: err=%b want 1", er); end
      checks++; if (rd_beats !== rb || wr_beats !== wb || hit_count !== 16'd5 || miss_count !== 16'd5) begin errors++; $display("FAIL mis_side: rd=%0d wr=%0d hits=%0d miss=%0d want 0 0 5 5", rd_beats - rb, wr_beats - wb, hit_count, miss_count); end
      access(1'b0, 2'b00, 32'h43, 32'h0, rd, er, cyc);
      checks++; if (er !== 1'b0 || rd !== 32'h40 || hit_count !== 16'd6) begin errors++; $display("FAIL byte_load: err=%b rdata=%h hits=%0d want 0 40 6", er, rd, hit_count); end
   endtask

   task automatic test_flush;
      logic [31:0] rd; logic er; int cyc, rb;
      @(negedge clk); #1; flush = 1'b1;
      @(negedge clk); #1; flush = 1'b0;
      rb = rd_beats;
      access(1'b0, 2'b10, 32'h40, 32'h0, rd, er, cyc);
      checks++; if (rd_beats - rb !== 16 || miss_count !== 16'd6) begin errors++; $display("FAIL flush_miss: beats=%0d miss=%0d want 16 6", rd_beats - rb, miss_count); end
      // flush and req together: flush wins, the request then misses
      @(negedge clk); #1; flush = 1'b1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h44;
      @(negedge clk); #1; flush = 1'b0;
      checks++; if (mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL flush_wins: mem_req=%b done=%b want 0 0", mem_req, done); end
      for (int n = 0; n < 100 && !done; n++) begin @(negedge clk); #1; end
      checks++; if (done !== 1'b1 || rdata !== 32'h44 || miss_count !== 16'd7) begin errors++; $display("FAIL flush_req: done=%b rdata=%h miss=%0d want 1 44 7", done, rdata, miss_count); end
      req = 1'b0;
   endtask

   task automatic test_reset_mid_refill;
      logic [31:0] rd; logic er; int cyc, rb;
      rb = rd_beats;
      @(negedge clk); #1; req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h80;
      for (int n = 0; n < 100 && (rd_beats - rb) < 5; n++) begin @(negedge clk); #1; end
      rst_n = 1'b0; req = 1'b0; #1;
      checks++; if (mem_req !== 1'b0 || hit_count !== 16'd0 || miss_count !== 16'd0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset: mem_req=%b hits=%0d miss=%0d done=%b want 0 0 0 0", mem_req, hit_count, miss_count, done); end
      @(negedge clk); #1; rst_n = 1'b1;
      rb = rd_beats;
      access(1'b0, 2'b10, 32'h80, 32'h0, rd, er, cyc);
      checks++; if (rd_beats - rb !== 16 || rd !== 32'h80 || miss_count !== 16'd1) begin errors++; $display("FAIL reload: beats=%0d rdata=%h miss=%0d want 16 80 1", rd_beats - rb, rd, miss_count); end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1; test_reset();
      rst_n = 1'b1;
      test_cold_load();
      test_sub_word_store();
      test_store_miss();
      test_conflict();
      test_misaligned();
      test_flush();
      test_reset_mid_refill();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
